clk_gen_multi: RTL

Multi-channel programmable clock-enable generator for the fan controller. It is the parametrised successor to the single fixed-ratio clock block. From one system clock it produces `NUM_CH` independent divided clock outputs and period ticks, for the PWM, display scan and key sampling logic. Each channel's divide ratio is reprogrammable at run time through a valid/ready port, and a new ratio takes effect only at that channel's period boundary, so outputs never glitch.

---
 rtl/clk_gen_pkg.sv | 21 ++
 rtl/clk_gen_chan.sv | 108 ++++++++++
 rtl/clk_gen_multi.sv | 63 ++++++
 3 files changed

// File: rtl/clk_gen_pkg.sv
// Shared constants and types for the multi-channel clock-enable generator.
// Optional duty-cycle support is selected with the CLK_GEN_DUTY_EN macro.
package clk_gen_pkg;

    // Smallest divide ratio a channel will ever run at.
    localparam int CLK_GEN_DIV_MIN = 2;

    // Default counter width used by the shared configuration record.
    parameter int CLK_GEN_DIV_W = 16;

    typedef struct packed {
        logic [CLK_GEN_DIV_W-1:0] div;
        logic [CLK_GEN_DIV_W-1:0] high;
    } ch_cfg_t;

    // Apply the lower bound on a requested divide ratio.
    function automatic int clamp_div(input int req);
        return (req < CLK_GEN_DIV_MIN) ? CLK_GEN_DIV_MIN : req;
    endfunction

endpackage

// File: rtl/clk_gen_chan.sv
// One divider channel: period counter, active and pending configuration, registered outputs.
// With CLK_GEN_DUTY_EN the written high time is used; otherwise high = div>>1.
module clk_gen_chan
    import clk_gen_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    input  logic [DIV_W-1:0] wr_high,
    input  logic             en,
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(CLK_GEN_DIV_MIN);
    localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] HIGH_RST = DIV_RST >> 1;

    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] high_reg;
    logic [DIV_W-1:0] pend_div_reg;
    logic [DIV_W-1:0] pend_high_reg;
    logic             pend_reg;
    logic             run_reg;
    logic             clk_out_reg;
    logic             tick_reg;

    logic [DIV_W-1:0] wr_div_clamped;
    logic [DIV_W-1:0] wr_high_clamped;
    logic [DIV_W-1:0] cnt_next;
    logic [DIV_W-1:0] div_next;
    logic [DIV_W-1:0] high_next;
    logic             apply;

    always_comb begin
        wr_div_clamped = (wr_div < DIV_MIN) ? DIV_MIN : wr_div;
`ifdef CLK_GEN_DUTY_EN
        wr_high_clamped = (wr_high > wr_div_clamped) ? wr_div_clamped : wr_high;
`else
        wr_high_clamped = wr_div_clamped >> 1;
`endif
    end

`ifndef CLK_GEN_DUTY_EN
    logic unused_high;
    assign unused_high = ^wr_high;
`endif

    // A period boundary is a wrap, the first enabled edge, or any disabled edge;
    // only there may the pending configuration become active.
    always_comb begin
        apply    = 1'b0;
        cnt_next = '0;
        if (!en || !run_reg) begin
            apply = pend_reg;
        end else if (cnt_reg == div_reg - 1'b1) begin
            apply = pend_reg;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
        div_next  = apply ? pend_div_reg  : div_reg;
        high_next = apply ? pend_high_reg : high_reg;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_reg       <= '0;
            div_reg       <= DIV_RST;
            high_reg      <= HIGH_RST;
            pend_div_reg  <= DIV_RST;
            pend_high_reg <= HIGH_RST;
            pend_reg      <= 1'b0;
            run_reg       <= 1'b0;
            clk_out_reg   <= 1'b0;
            tick_reg      <= 1'b0;
        end else begin
            run_reg  <= en;
            cnt_reg  <= cnt_next;
            div_reg  <= div_next;
            high_reg <= high_next;
            if (apply) begin
                pend_reg <= 1'b0;
            end
            // A write is only offered while the slot is empty, so it never meets an apply.
            if (wr) begin
                pend_reg      <= 1'b1;
                pend_div_reg  <= wr_div_clamped;
                pend_high_reg <= wr_high_clamped;
            end
            clk_out_reg <= en && (cnt_next < high_next);
            tick_reg    <= en && (cnt_next == div_next - 1'b1);
        end
    end

    assign pending = pend_reg;
    assign clk_out = clk_out_reg;
    assign tick    = tick_reg;

    assert property (@(posedge clk_in) disable iff (rst) !(wr && pend_reg));
    assert property (@(posedge clk_in) disable iff (rst) div_reg >= DIV_MIN);

endmodule

// File: rtl/clk_gen_multi.sv
// Multi-channel programmable clock-enable generator with a shared valid/ready config port.
// Define CLK_GEN_DUTY_EN to honour cfg_high; otherwise each channel runs at ~50% duty.
module clk_gen_multi
    import clk_gen_pkg::*;
#(
    parameter int  NUM_CH      = 4,
    parameter int  DIV_W       = 16,
    parameter int  DEFAULT_DIV = 2,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_high,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam int SLOTS = 1 << CH_W;

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] wr;
    logic [SLOTS-1:0]  busy;

    // Indices beyond NUM_CH read as permanently busy, so they can never be written.
    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_busy
            if (gi < NUM_CH) begin : g_real
                assign busy[gi] = pending[gi];
            end else begin : g_void
                assign busy[gi] = 1'b1;
            end
        end
    endgenerate

    assign cfg_ready = ~rst & ~busy[cfg_ch];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign wr[gi] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(gi));

            clk_gen_chan #(
                .DIV_W      (DIV_W),
                .DEFAULT_DIV(DEFAULT_DIV)
            ) u_chan (
                .clk_in (clk_in),
                .rst    (rst),
                .wr     (wr[gi]),
                .wr_div (cfg_div),
                .wr_high(cfg_high),
                .en     (ch_en[gi]),
                .pending(pending[gi]),
                .clk_out(clk_out[gi]),
                .tick   (tick[gi])
            );
        end
    endgenerate

endmodule
